// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative RV32M multiply/divide unit sitting in EX behind the ID/EX
//   register. Multiplies by shift-add and divides by restoring division,
//   one bit per clock, on operand magnitudes; signs are reapplied when
//   the result is formed. Division by zero and signed overflow finish
//   without iterating.
//
//   Ports:
//     clk        pipeline clock, rising edge
//     rst        asynchronous active-high reset
//     flush      synchronous abort (pipeline redirect)
//     start      EX holds a valid M-extension instruction
//     funct3     M-extension operation select
//     op_a/op_b  forwarded rs1/rs2 values
//     rd_in      destination register of the instruction
//     stall_req  hold IF/ID and ID/EX while the unit is busy
//     done       one-cycle result-valid pulse
//     result     result, held until the next completion
//     rd_out     destination register that goes with result
//
//   state | meaning
//   IDLE  | waiting for start; operands and sign flags latched on accept
//   CALC  | one multiply/divide iteration per cycle, counter counts down
//   DONE  | sign fix-up; result/rd_out/done registered on leaving
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              neg_q;
  logic              neg_r;
  logic              special;
  logic [XLEN-1:0]   special_val;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;

  // operand decode at accept time
  logic            signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0] mag_a_in, mag_b_in;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_in;

  always_comb begin
    signed_a   = !funct3[0] || (funct3 == 3'b001);
    signed_b   = funct3 inside {3'b000, 3'b001, 3'b100, 3'b110};
    sign_a     = signed_a && op_a[XLEN-1];
    sign_b     = signed_b && op_b[XLEN-1];
    mag_a_in   = sign_a ? -op_a : op_a;
    mag_b_in   = sign_b ? -op_b : op_b;
    div_zero   = funct3[2] && (op_b == {XLEN{1'b0}});
    div_ovf    = funct3[2] && !funct3[0] &&
                 (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == {XLEN{1'b1}});
    special_in = {XLEN{1'b0}};
    if (div_zero)
      special_in = funct3[1] ? op_a : {XLEN{1'b1}};
    else if (div_ovf)
      special_in = funct3[1] ? {XLEN{1'b0}} : op_a;
  end

  // multiply step: add multiplicand into the high half when the current
  // multiplier bit (acc[0]) is set, then shift the whole accumulator right
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mag_a : {XLEN{1'b0}})};
    mul_next = {mul_sum, acc[XLEN-1:1]};
  end

  // divide step: high half is the partial remainder, low half shifts the
  // dividend out and the quotient bits in
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_sub;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    rem_ge   = rem_sh >= {1'b0, mag_b};
    // the difference always fits XLEN bits when rem_ge holds
    rem_sub  = rem_sh[XLEN-1:0] - mag_b;
    div_next = {(rem_ge ? rem_sub : rem_sh[XLEN-1:0]), acc[XLEN-2:0], rem_ge};
  end

  // sign fix-up and result select
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, final_val;

  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (special)
      final_val = special_val;
    else if (op_q[2])
      final_val = op_q[1] ? rem : quo;
    else if (op_q[1:0] == 2'b00)
      final_val = prod[XLEN-1:0];
    else
      final_val = prod[2*XLEN-1:XLEN];
  end

  assign stall_req = !rst && (((state == IDLE) && start && !flush) || (state == CALC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= 3'b000;
      rd_q        <= 5'd0;
      mag_a       <= {XLEN{1'b0}};
      mag_b       <= {XLEN{1'b0}};
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      special     <= 1'b0;
      special_val <= {XLEN{1'b0}};
      acc         <= {(2*XLEN){1'b0}};
      cnt         <= {CW{1'b0}};
      done        <= 1'b0;
      result      <= {XLEN{1'b0}};
      rd_out      <= 5'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op_q        <= funct3;
            rd_q        <= rd_in;
            mag_a       <= mag_a_in;
            mag_b       <= mag_b_in;
            neg_q       <= sign_a ^ sign_b;
            neg_r       <= sign_a;
            special     <= div_zero || div_ovf;
            special_val <= special_in;
            if (div_zero || div_ovf) begin
              state <= DONE;
            end else begin
              // divide iterates over the dividend, multiply over the multiplier
              acc   <= {{XLEN{1'b0}}, (funct3[2] ? mag_a_in : mag_b_in)};
              cnt   <= CW'(XLEN-1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc <= op_q[2] ? div_next : mul_next;
            cnt <= cnt - 1'b1;
            if (cnt == {CW{1'b0}})
              state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          if (!flush) begin
            done   <= 1'b1;
            result <= final_val;
            rd_out <= rd_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Takes the forwarded operands and the funct3 of an M-extension instruction held in ID/EX (opcode 0110011, funct7 0000001).
- Asserts a stall back to ID/EX and IF/ID while computing.
- Presents a one-cycle result with its destination register to the EX/MEM path.

Parameters:
- XLEN, 32, operand/result width; also the iteration count for multiply and divide.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort (branch/jump redirect); same signal that flushes ID/EX.
- start  input  1  EX holds a valid M-extension instruction.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 value after forwarding.
- op_b  input  XLEN  rs2 value after forwarding.
- rd_in  input  5  destination register.
- stall_req  output  1  hold IF/ID and ID/EX.
- done  output  1  result valid this cycle.
- result  output  XLEN  final result.
- rd_out  output  5  destination register accompanying result.

Behaviour:
- Reset (async, rst=1): state=IDLE; done=0; result=0; rd_out=0; internal accumulator, operands and counter cleared. stall_req=0 while in reset.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and flush=0: latch funct3, rd_in, operand magnitudes and sign flags.
  - Normal case: load counter=XLEN-1 and go to CALC.
  - Special cases go directly to DONE.
  - start=0: stay.
- Special cases, zero iterations:
  - DIV/DIVU with op_b=0: quotient = all ones.
  - REM/REMU with op_b=0: result = op_a.
  - DIV with op_a=0x80000000 and op_b=0xFFFFFFFF: quotient = 0x80000000.
  - REM with the same overflow operands: result = 0.
- CALC: one iteration per cycle. Counter decrements; when counter=0, the next state is DONE.
  - Multiply: shift-add over a 2*XLEN accumulator, unsigned on magnitudes.
  - Divide: restoring, one quotient bit per cycle, unsigned on magnitudes.
- DONE (exactly one cycle):
  - done=1; result and rd_out registered.
  - Next state is IDLE unconditionally; start is ignored in DONE so the same instruction is never reissued.
- Signed handling:
  - MUL/MULH: op_a and op_b signed.
  - MULHSU: op_a signed, op_b unsigned.
  - DIV/REM: both signed.
  - Product sign = XOR of the signed operand signs.
  - Quotient sign = XOR of the operand signs.
  - Remainder sign = dividend sign.
  - Two's-complement negation applies at DONE entry.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Latency, with start accepted at rising edge T:
  - Normal: done=1 in the cycle following edge T+XLEN+1 (33 edges for XLEN=32).
  - Special case: done=1 in the cycle after edge T+1.
- stall_req (combinational): (state==IDLE and start and !flush) or state==CALC.
  - stall_req is low in DONE, so ID/EX advances on the DONE edge.
- done and result are registered and held. done drops after one cycle; result and rd_out hold their value until the next DONE.
- Flush:
  - In CALC or DONE: next state IDLE, done=0 next cycle, computation discarded.
  - Coincident with start in IDLE: start is ignored.
- Reset mid-CALC: immediate return to IDLE, no done pulse.
- Back-to-back instructions: the next M-instruction arrives in the cycle after DONE; IDLE accepts it the same cycle.
- The unit never writes registers itself; the downstream consumer muxes result when done=1.

Test Plan:
- MUL, op_a=7, op_b=0xFFFFFFFD (-3) -> stall_req high for 33 cycles; done pulses once; result=0xFFFFFFEB; rd_out=rd_in.
- MULHU, op_a=op_b=0xFFFFFFFF -> result=0xFFFFFFFE. Same operands with MULH -> result=0x00000000. MULHSU -> result=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> done one cycle after accept, result=0x80000000. REM with the same operands -> 0. DIVU 5 / 0 -> 0xFFFFFFFF. REMU 5 / 0 -> 5.
- DIV -7 / 2 -> 0xFFFFFFFD (-3). REM -7 / 2 -> 0xFFFFFFFF (-1). DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2. Each done at 33 cycles.
- Flush at iteration 10 of DIVU -> stall_req drops the next cycle; no done; a new MUL started 2 cycles later completes correctly.
- rst asserted asynchronously mid-CALC (between clock edges) -> done, result and rd_out go to 0 immediately and stall_req drops. Two back-to-back MULs after rst release -> two done pulses 34 cycles apart.
